key_debounce_blck: RTL and testbench

Per-key debounce and edge-detect stage between the board push-buttons and the key/LED status block. It synchronises each raw key input, filters contact bounce with a per-key stability counter, and presents a clean key row. It also emits one-cycle press and release pulses. The clean row drives the downstream key/LED block's `i_key_row`.

---
 rtl/key_pkg.sv | 21 ++
 rtl/key_debounce_unit.sv | 101 ++++++++++
 rtl/key_debounce_blck.sv | 41 ++++
 tb/tb_key_debounce_blck.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared key/LED constants: debounce FSM encoding, default polarities and timing.
package key_pkg;

  localparam logic ST_STABLE = 1'b0;
  localparam logic ST_COUNT  = 1'b1;

  typedef enum logic {
    S_STABLE = ST_STABLE,
    S_COUNT  = ST_COUNT
  } deb_state_e;

  // Pressed-key level and lit-LED level, shared with the key/LED block.
  localparam logic MD_PRESS = 1'b0;
  localparam logic MD_LIGHT = 1'b1;

  localparam int unsigned DEF_WD_KEY      = 4;
  localparam int unsigned DEF_WD_CNT      = 20;
  // 20 ms at 50 MHz.
  localparam logic [19:0] DEF_NB_DEBOUNCE = 20'd1_000_000;

endpackage

// File: rtl/key_debounce_unit.sv
// Single-key debounce: 2-flop synchroniser, stability counter, 2-state FSM,
// registered clean level and one-cycle press/release pulses.
// Ports:
//   i_sys_clk   system clock
//   i_rst_n     synchronous active-low reset
//   i_key_raw   raw asynchronous key pin
//   o_key       debounced level (same polarity as the pin)
//   o_press     one-cycle pulse when o_key becomes MD_PRESS
//   o_release   one-cycle pulse when o_key becomes ~MD_PRESS
module key_debounce_unit
  import key_pkg::*;
#(
  parameter int unsigned          WD_CNT      = DEF_WD_CNT,
  parameter logic [WD_CNT-1:0]    NB_DEBOUNCE = WD_CNT'(DEF_NB_DEBOUNCE),
  parameter logic                 MD_PRESS    = key_pkg::MD_PRESS
) (
  input  logic i_sys_clk,
  input  logic i_rst_n,
  input  logic i_key_raw,
  output logic o_key,
  output logic o_press,
  output logic o_release
);

  localparam logic [WD_CNT-1:0] LP_CNT_LAST = NB_DEBOUNCE - WD_CNT'(1);

  deb_state_e        r_state;
  deb_state_e        w_state_nxt;
  logic              r_s1;
  logic              r_s2;
  logic              r_key;
  logic              r_press;
  logic              r_release;
  logic [WD_CNT-1:0] r_cnt;
  logic [WD_CNT-1:0] w_cnt_nxt;
  logic              w_key_nxt;
  logic              w_press_nxt;
  logic              w_release_nxt;

  // State, synchroniser and output registers.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_STABLE;
      r_s1      <= ~MD_PRESS;
      r_s2      <= ~MD_PRESS;
      r_key     <= ~MD_PRESS;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_s1      <= i_key_raw;
      r_s2      <= r_s1;
      r_key     <= w_key_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Next state: a change is accepted only after s2 disagrees with the clean
  // level continuously until the counter reaches its last value.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_key_nxt     = r_key;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      S_STABLE: begin
        w_cnt_nxt = '0;
        if (r_s2 != r_key) begin
          w_state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (r_s2 == r_key) begin
          w_state_nxt = S_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt   = S_STABLE;
          w_cnt_nxt     = '0;
          w_key_nxt     = r_s2;
          w_press_nxt   = (r_s2 == MD_PRESS);
          w_release_nxt = (r_s2 != MD_PRESS);
        end else begin
          w_cnt_nxt = r_cnt + WD_CNT'(1);
        end
      end
      default: begin
        w_state_nxt = S_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_key     = r_key;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/key_debounce_blck.sv
// Debounce and edge-detect for a row of push-buttons; one independent
// key_debounce_unit per key.
// Ports:
//   i_sys_clk      system clock
//   i_rst_n        synchronous active-low reset
//   i_key_raw      raw asynchronous key pins
//   o_key_row      debounced key levels, same polarity as the pins
//   o_key_press    per-key one-cycle press pulses
//   o_key_release  per-key one-cycle release pulses
module key_debounce_blck
  import key_pkg::*;
#(
  parameter int unsigned       WD_KEY      = DEF_WD_KEY,
  parameter int unsigned       WD_CNT      = DEF_WD_CNT,
  parameter logic [WD_CNT-1:0] NB_DEBOUNCE = WD_CNT'(DEF_NB_DEBOUNCE),
  parameter logic              MD_PRESS    = key_pkg::MD_PRESS
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,
  input  logic [WD_KEY-1:0] i_key_raw,
  output logic [WD_KEY-1:0] o_key_row,
  output logic [WD_KEY-1:0] o_key_press,
  output logic [WD_KEY-1:0] o_key_release
);

  for (genvar g = 0; g < WD_KEY; g++) begin : g_key
    key_debounce_unit #(
      .WD_CNT      (WD_CNT),
      .NB_DEBOUNCE (NB_DEBOUNCE),
      .MD_PRESS    (MD_PRESS)
    ) u_unit (
      .i_sys_clk (i_sys_clk),
      .i_rst_n   (i_rst_n),
      .i_key_raw (i_key_raw[g]),
      .o_key     (o_key_row[g]),
      .o_press   (o_key_press[g]),
      .o_release (o_key_release[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_blck.sv
// Randomized and directed bench for key_debounce_blck against a run-length
// reference model (a key is accepted after NB+1 consecutive disagreeing
// synchronised samples).
module tb_key_debounce_blck;

  localparam int unsigned NK = 4;
  localparam int unsigned NB = 4;
  localparam int unsigned WC = 8;
  localparam logic        MP = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_row;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_debounce_blck #(
    .WD_KEY      (NK),
    .WD_CNT      (WC),
    .NB_DEBOUNCE (WC'(NB)),
    .MD_PRESS    (MP)
  ) dut (
    .i_sys_clk     (clk),
    .i_rst_n       (rst_n),
    .i_key_raw     (key_raw),
    .o_key_row     (key_row),
    .o_key_press   (key_press),
    .o_key_release (key_release)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  // Reference model: raw is seen two edges late; a key flips after NB+1
  // consecutive edges where that delayed level disagrees with the clean level.
  logic [NK-1:0] m_dly1, m_dly2, m_clean, m_press, m_rel;
  int            m_run [NK];

  task automatic model_step(input logic rst, input logic [NK-1:0] raw);
    if (!rst) begin
      m_dly1  = {NK{~MP}};
      m_dly2  = {NK{~MP}};
      m_clean = {NK{~MP}};
      m_press = '0;
      m_rel   = '0;
      for (int k = 0; k < NK; k++) m_run[k] = 0;
    end else begin
      m_press = '0;
      m_rel   = '0;
      for (int k = 0; k < NK; k++) begin
        if (m_dly2[k] != m_clean[k]) begin
          m_run[k]++;
          if (m_run[k] == NB + 1) begin
            m_clean[k] = m_dly2[k];
            if (m_clean[k] == MP) m_press[k] = 1'b1;
            else                  m_rel[k]   = 1'b1;
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_dly2 = m_dly1;
      m_dly1 = raw;
    end
  endtask

  // Apply inputs for one edge, advance the model, compare #1 after the edge.
  task automatic do_cycle(input logic rst, input logic [NK-1:0] raw);
    rst_n   = rst;
    key_raw = raw;
    @(posedge clk);
    model_step(rst, raw);
    #1;
    chk("row", 32'(key_row), 32'(m_clean));
    chk("press", 32'(key_press), 32'(m_press));
    chk("release", 32'(key_release), 32'(m_rel));
  endtask

  initial begin
    logic [NK-1:0] raw;
    int            hold [NK];
    int            found;
    int            e;

    rst_n   = 1'b0;
    key_raw = '0;
    #2;

    // Reset with all keys held, then release: all keys re-qualify as presses.
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 4'b0000);
    chk("rst_row", 32'(key_row), 32'hF);
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 4'b0000);
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 4'b1111);

    // Clean press of key 0: clean level at edge 6, single press pulse.
    found = -1;
    e     = 0;
    while (found < 0 && e < 20) begin
      do_cycle(1'b1, 4'b1110);
      if (key_row[0] == 1'b0) found = e;
      e++;
    end
    chk("lat_edge", 32'(found), 32'd6);
    chk("lat_press", 32'(key_press), 32'h1);
    do_cycle(1'b1, 4'b1110);
    chk("lat_press_end", 32'(key_press), 32'h0);

    // Bounce on key 1, then settle low.
    raw = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      raw[1] = ~raw[1];
      do_cycle(1'b1, raw);
    end
    raw[1] = 1'b0;
    for (int i = 0; i < 12; i++) do_cycle(1'b1, raw);

    // Glitch on key 2 shorter than qualification.
    raw[2] = 1'b0;
    for (int i = 0; i < 3; i++) do_cycle(1'b1, raw);
    raw[2] = 1'b1;
    for (int i = 0; i < 10; i++) do_cycle(1'b1, raw);
    chk("glitch_row", 32'(key_row), 32'hC);

    // Simultaneous release of key 0 and press of key 3.
    raw = 4'b0101;
    for (int i = 0; i < 7; i++) do_cycle(1'b1, raw);
    chk("simul_rel", 32'(key_release), 32'h1);
    chk("simul_press", 32'(key_press), 32'h8);
    for (int i = 0; i < 5; i++) do_cycle(1'b1, raw);

    // Reset mid-count on a key 0 press.
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 4'b1111);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 4'b1110);
    do_cycle(1'b0, 4'b1110);
    chk("midrst_row", 32'(key_row), 32'hF);
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 4'b1110);

    // Random per-key hold lengths around the qualification window.
    raw = 4'b1111;
    for (int k = 0; k < NK; k++) hold[k] = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < NK; k++) begin
        if (hold[k] == 0) begin
          raw[k]  = 1'($urandom_range(0, 1));
          hold[k] = int'($urandom_range(1, 9));
        end else begin
          hold[k]--;
        end
      end
      do_cycle(($urandom_range(0, 299) != 0), raw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
